// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the prefetch entry layout for the ROM fetch path
package fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO; flush wins over push and pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fetch_entry_t,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  T              din,
  output T              head,
  output logic [CW-1:0] count
);
  T              r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_wp_nx, w_rp_nx;
  always_comb begin
    w_wp_nx = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
    w_rp_nx = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= w_wp_nx;
      end
      if (pop) r_rp <= w_rp_nx;
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  end
  assign head  = r_mem[r_rp];
  assign count = r_cnt;
endmodule

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: PC sequencer sharing one ROM port between prefetch and debug reads
module rom_fetch_ctrl #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ack;
  logic [DATA_W-1:0] r_dbg_data;
  logic              w_gnt, w_pop, w_fetch;
  logic [CW-1:0]     w_count;
  entry_t            w_head, w_din;
  // Blocking the grant while acking leaves fetch at least every other slot
  always_comb begin
    w_gnt     = dbg_req && !r_ack;
    rom_addr  = w_gnt ? dbg_addr : r_pc;
    out_valid = (w_count != '0) && !redirect_valid;
    w_pop     = out_valid && out_ready;
    w_fetch   = !halt && !redirect_valid && !w_gnt && (w_count < CW'(DEPTH) || w_pop);
    w_din     = '{pc: r_pc, data: rom_data};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc       <= '0;
      r_ack      <= 1'b0;
      r_dbg_data <= '0;
    end else begin
      r_pc  <= redirect_valid ? redirect_addr : w_fetch ? r_pc + 1'b1 : r_pc;
      r_ack <= w_gnt;
      if (w_gnt) r_dbg_data <= rom_data;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_fetch),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_din),
    .head  (w_head),
    .count (w_count)
  );
  assign out_data = w_head.data;
  assign out_pc   = w_head.pc;
  assign dbg_ack  = r_ack;
  assign dbg_data = r_dbg_data;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed scenario tasks against a small program ROM image
module tb_rom_fetch_ctrl;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] rom_addr, rom_data;
  logic       out_valid, out_ready = 0;
  logic [7:0] out_data, out_pc;
  logic       redirect_valid = 0;
  logic [7:0] redirect_addr = 0;
  logic       halt = 0, dbg_req = 0;
  logic [7:0] dbg_addr = 0;
  logic       dbg_ack;
  logic [7:0] dbg_data;
  logic [7:0] rom [256];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  rom_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt(halt),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 0; out_ready = rdy; redirect_valid = 0; redirect_addr = 0;
    halt = 0; dbg_req = 0; dbg_addr = 0;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset(0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_pc !== 8'h00 || out_data !== 8'h00) begin n_fail++; $display("FAIL reset_head got %h/%h want 00/00", out_pc, out_data); end
    n_checks++; if (dbg_ack !== 1'b0 || dbg_data !== 8'h00) begin n_fail++; $display("FAIL reset_dbg got %b/%h want 0/00", dbg_ack, dbg_data); end
    n_checks++; if (dut.w_count !== 2'd0 || dut.r_pc !== 8'h00) begin n_fail++; $display("FAIL reset_state got cnt %0d pc %h want 0/00", dut.w_count, dut.r_pc); end
  endtask

  task automatic test_stream();
    logic [7:0] d [4] = '{8'h02, 8'h86, 8'h01, 8'h86};
    do_reset(1);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'(i) || out_data !== d[i]) begin
        n_fail++; $display("FAIL stream_%0d got v%b {%h,%h} want v1 {%h,%h}", i, out_valid, out_pc, out_data, 8'(i), d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d [3] = '{8'h02, 8'h86, 8'h01};
    do_reset(0);
    rst_n = 1;
    repeat (5) tick();
    n_checks++; if (dut.w_count !== 2'd2 || dut.r_pc !== 8'h02) begin n_fail++; $display("FAIL bp_full got cnt %0d pc %h want 2/02", dut.w_count, dut.r_pc); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'(i) || out_data !== d[i]) begin
        n_fail++; $display("FAIL bp_drain_%0d got v%b {%h,%h} want v1 {%h,%h}", i, out_valid, out_pc, out_data, 8'(i), d[i]);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [7:0] d [3] = '{8'hB3, 8'h14, 8'hC1};
    do_reset(0);
    rst_n = 1;
    tick(); tick();
    redirect_valid = 1; redirect_addr = 8'h0D; out_ready = 1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", out_valid); end
    tick();
    redirect_valid = 0;
    n_checks++; if (dut.w_count !== 2'd0 || dut.r_pc !== 8'h0D) begin n_fail++; $display("FAIL redir_flush got cnt %0d pc %h want 0/0D", dut.w_count, dut.r_pc); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 8'(8'h0D + i) || out_data !== d[i]) begin
        n_fail++; $display("FAIL redir_%0d got v%b {%h,%h} want v1 {%h,%h}", i, out_valid, out_pc, out_data, 8'(8'h0D + i), d[i]);
      end
    end
  endtask

  task automatic test_debug();
    logic [7:0] d [4] = '{8'h02, 8'h86, 8'h01, 8'h86};
    do_reset(1);
    rst_n = 1; dbg_req = 1; dbg_addr = 8'h12;
    #1;
    n_checks++; if (rom_addr !== 8'h12) begin n_fail++; $display("FAIL dbg_addr got %h want 12", rom_addr); end
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e % 2 == 1) begin
        n_checks++;
        if (dbg_ack !== 1'b1 || dbg_data !== 8'h0D || out_valid !== 1'b0) begin
          n_fail++; $display("FAIL dbg_ack_%0d got ack%b data %h v%b want ack1 data 0D v0", e, dbg_ack, dbg_data, out_valid);
        end
      end else begin
        n_checks++;
        if (dbg_ack !== 1'b0 || out_valid !== 1'b1 || out_pc !== 8'(e / 2 - 1) || out_data !== d[e/2-1]) begin
          n_fail++; $display("FAIL dbg_fetch_%0d got ack%b v%b {%h,%h} want ack0 v1 {%h,%h}", e, dbg_ack, out_valid, out_pc, out_data, 8'(e / 2 - 1), d[e/2-1]);
        end
      end
    end
    dbg_req = 0;
  endtask

  task automatic test_wrap();
    logic [7:0] p [3] = '{8'hFE, 8'hFF, 8'h00};
    logic [7:0] d [3] = '{8'h00, 8'h00, 8'h02};
    do_reset(1);
    rst_n = 1; redirect_valid = 1; redirect_addr = 8'hFE;
    tick();
    redirect_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== p[i] || out_data !== d[i]) begin
        n_fail++; $display("FAIL wrap_%0d got v%b {%h,%h} want v1 {%h,%h}", i, out_valid, out_pc, out_data, p[i], d[i]);
      end
    end
  endtask

  task automatic test_halt_reset();
    do_reset(0);
    rst_n = 1;
    tick(); tick();
    halt = 1; out_ready = 1;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 8'h01 || dut.w_count !== 2'd1) begin n_fail++; $display("FAIL halt_drain got v%b pc %h cnt %0d want v1 01 1", out_valid, out_pc, dut.w_count); end
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0 || dut.r_pc !== 8'h02) begin n_fail++; $display("FAIL halt_hold got v%b pc %h want v0 02", out_valid, dut.r_pc); end
    halt = 0; out_ready = 0;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 8'h02 || out_data !== 8'h01) begin n_fail++; $display("FAIL halt_resume got v%b {%h,%h} want v1 {02,01}", out_valid, out_pc, out_data); end
    tick();
    dbg_req = 1; dbg_addr = 8'h12; rst_n = 0;
    tick();
    n_checks++; if (dut.w_count !== 2'd0 || dut.r_pc !== 8'h00) begin n_fail++; $display("FAIL midrst_state got cnt %0d pc %h want 0/00", dut.w_count, dut.r_pc); end
    n_checks++; if (dbg_ack !== 1'b0 || dbg_data !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out got ack%b data %h v%b want 0 00 0", dbg_ack, dbg_data, out_valid); end
    dbg_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h02; rom[8'h01] = 8'h86; rom[8'h02] = 8'h01; rom[8'h03] = 8'h86;
    rom[8'h0D] = 8'hB3; rom[8'h0E] = 8'h14; rom[8'h0F] = 8'hC1; rom[8'h12] = 8'h0D;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_debug();
    test_wrap();
    test_halt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
